hdmi_pixel_packer: RTL and testbench

//  Parametrised successor to the fixed 24->32 HDMI ingester. Packs IN_WIDTH-bit pixels

---
 rtl/hdmi_pkg.sv | 30 +++
 rtl/hdmi_pixel_packer_if.sv | 29 ++
 rtl/hdmi_sync_edge.sv | 25 ++
 rtl/hdmi_pixel_packer.sv | 133 +++++++++++++
 tb/tb_hdmi_pixel_packer.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// Shared constants and helpers for the HDMI pixel packer: byte geometry of the default
// 24->32 configuration, a constant clog2 and the sync-polarity helper.
package hdmi_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] hdmiByte_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  // Accumulator holds up to OUT-1 residual bytes plus one incoming pixel.
  function automatic int unsigned fillWidth(input int unsigned inBytes,
                                            input int unsigned outBytes);
    return clog2(inBytes + outBytes);
  endfunction

  localparam int unsigned IN_BYTES  = 3;
  localparam int unsigned OUT_BYTES = 4;
  localparam int unsigned FILL_W    = fillWidth(IN_BYTES, OUT_BYTES);

  function automatic logic syncActive(input logic sig, input bit actHigh);
    return actHigh ? sig : ~sig;
  endfunction

endpackage

// File: rtl/hdmi_pixel_packer_if.sv
// Pixel ingest and FIFO-write bundle of the HDMI pixel packer; master drives pixels and
// FIFO status, slave is the packer.
interface hdmi_pixel_packer_if #(
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned DROP_CNT_W = 16
);
  logic [IN_WIDTH-1:0]   hdmiData;
  logic                  hSync;
  logic                  vSync;
  logic                  dataEnable;
  logic                  hdmiEnable;
  logic                  fifoFull;
  logic                  clearStatus;
  logic [OUT_WIDTH-1:0]  fifoData;
  logic                  dataValid;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] dropCount;

  modport master (
    output hdmiData, hSync, vSync, dataEnable, hdmiEnable, fifoFull, clearStatus,
    input  fifoData, dataValid, overflow, dropCount
  );

  modport slave (
    input  hdmiData, hSync, vSync, dataEnable, hdmiEnable, fifoFull, clearStatus,
    output fifoData, dataValid, overflow, dropCount
  );
endinterface

// File: rtl/hdmi_sync_edge.sv
// Polarity-corrected sync edge detector: flags the inactive->active transition of a sync
// input against a one-cycle registered copy.
module hdmi_sync_edge
  import hdmi_pkg::*;
#(
  parameter bit ACT_HIGH = 1'b1
) (
  input  logic i_hdmiClock,
  input  logic i_nReset,
  input  logic sync,
  output logic syncEdge
);
  logic active;
  logic activeQ;

  assign active = syncActive(sync, ACT_HIGH);

  always_ff @(posedge i_hdmiClock) begin
    if (!i_nReset) activeQ <= 1'b0;
    else           activeQ <= active;
  end

  assign syncEdge = active & ~activeQ;

endmodule

// File: rtl/hdmi_pixel_packer.sv
// Packs IN_WIDTH-bit HDMI pixels into OUT_WIDTH-bit FIFO words with sync-driven zero-padded
// flush and saturating drop accounting when the FIFO is full.
module hdmi_pixel_packer
  import hdmi_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = IN_BYTES * BYTE_W,
  parameter int unsigned OUT_WIDTH      = OUT_BYTES * BYTE_W,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter bit          FLUSH_ON_VSYNC = 1'b1,
  parameter bit          FLUSH_ON_HSYNC = 1'b0,
  parameter bit          SYNC_ACT_HIGH  = 1'b1,
  parameter int unsigned DROP_CNT_W     = 16
) (
  input logic                i_hdmiClock,
  input logic                i_nReset,
  hdmi_pixel_packer_if.slave bus
);
  localparam int unsigned InBytes  = IN_WIDTH / BYTE_W;
  localparam int unsigned OutBytes = OUT_WIDTH / BYTE_W;
  localparam int unsigned AccBytes = InBytes + OutBytes - 1;
  localparam int unsigned FillW    = (InBytes == IN_BYTES && OutBytes == OUT_BYTES) ?
                                     FILL_W : fillWidth(InBytes, OutBytes);

  // Byte 0 of the accumulator is the oldest byte in stream order; unused slots stay zero.
  hdmiByte_t accQ [AccBytes];
  hdmiByte_t accD [AccBytes];
  hdmiByte_t merged [AccBytes];
  hdmiByte_t pixBytes [InBytes];
  hdmiByte_t wordBytes [OutBytes];

  logic [FillW-1:0]      fillQ, fillD, baseFill, mergedFill;
  logic [OUT_WIDTH-1:0]  fifoDataQ, wordD;
  logic                  dataValidQ, dataValidD;
  logic                  overflowQ, overflowD;
  logic [DROP_CNT_W-1:0] dropCountQ, dropCountD;
  logic                  hEdge, vEdge;
  logic                  pixelIn, flushReq, wordFull, emit, drop;

  hdmi_sync_edge #(.ACT_HIGH(SYNC_ACT_HIGH)) uHSyncEdge (
    .i_hdmiClock(i_hdmiClock),
    .i_nReset   (i_nReset),
    .sync       (bus.hSync),
    .syncEdge   (hEdge)
  );

  hdmi_sync_edge #(.ACT_HIGH(SYNC_ACT_HIGH)) uVSyncEdge (
    .i_hdmiClock(i_hdmiClock),
    .i_nReset   (i_nReset),
    .sync       (bus.vSync),
    .syncEdge   (vEdge)
  );

  always_comb begin
    for (int i = 0; i < InBytes; i++) begin
      pixBytes[i] = bus.hdmiData[IN_WIDTH-1-BYTE_W*i -: BYTE_W];
    end

    pixelIn  = bus.hdmiEnable & bus.dataEnable;
    flushReq = bus.hdmiEnable & ((FLUSH_ON_VSYNC & vEdge) | (FLUSH_ON_HSYNC & hEdge)) &
               (fillQ != '0);

    // A flush empties the accumulator first so a coincident pixel lands at byte 0.
    baseFill = flushReq ? '0 : fillQ;
    for (int j = 0; j < AccBytes; j++) begin
      merged[j] = flushReq ? '0 : accQ[j];
      if (pixelIn) begin
        for (int i = 0; i < InBytes; i++) begin
          if (FillW'(j) == baseFill + FillW'(i)) merged[j] = pixBytes[i];
        end
      end
    end
    mergedFill = pixelIn ? baseFill + FillW'(InBytes) : baseFill;

    wordFull = !flushReq && (mergedFill >= FillW'(OutBytes));
    emit     = flushReq | wordFull;
    drop     = emit & bus.fifoFull;

    for (int k = 0; k < OutBytes; k++) begin
      wordBytes[k] = flushReq ? accQ[k] : merged[k];
    end

    wordD = '0;
    for (int k = 0; k < OutBytes; k++) begin
      if (MSB_FIRST) wordD[OUT_WIDTH-1-BYTE_W*k -: BYTE_W] = wordBytes[k];
      else           wordD[BYTE_W*k +: BYTE_W]             = wordBytes[k];
    end

    // A dropped word still consumes its bytes to keep pixel alignment.
    for (int j = 0; j < AccBytes; j++) begin
      if (!wordFull)                   accD[j] = merged[j];
      else if (j + OutBytes < AccBytes) accD[j] = merged[j+OutBytes];
      else                             accD[j] = '0;
    end
    fillD = wordFull ? mergedFill - FillW'(OutBytes) : mergedFill;

    dataValidD = emit & ~bus.fifoFull;

    overflowD  = overflowQ;
    dropCountD = dropCountQ;
    if (bus.clearStatus) begin
      overflowD  = 1'b0;
      dropCountD = '0;
    end
    if (drop) begin
      overflowD = 1'b1;
      if (dropCountD != '1) dropCountD = dropCountD + 1'b1;
    end
  end

  always_ff @(posedge i_hdmiClock) begin
    if (!i_nReset) begin
      accQ       <= '{default: '0};
      fillQ      <= '0;
      fifoDataQ  <= '0;
      dataValidQ <= 1'b0;
      overflowQ  <= 1'b0;
      dropCountQ <= '0;
    end else begin
      accQ       <= accD;
      fillQ      <= fillD;
      dataValidQ <= dataValidD;
      overflowQ  <= overflowD;
      dropCountQ <= dropCountD;
      if (dataValidD) fifoDataQ <= wordD;
    end
  end

  assign bus.fifoData  = fifoDataQ;
  assign bus.dataValid = dataValidQ;
  assign bus.overflow  = overflowQ;
  assign bus.dropCount = dropCountQ;

endmodule

// File: tb/tb_hdmi_pixel_packer.sv
// Directed bench for hdmi_pixel_packer: MSB-first and LSB-first 24->32 instances plus a
// 56->64 instance used to saturate the drop counter quickly.
module tb_hdmi_pixel_packer;
  logic clk = 1'b0;
  logic nReset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hdmi_pixel_packer_if #(.IN_WIDTH(24), .OUT_WIDTH(32), .DROP_CNT_W(16)) busA ();
  hdmi_pixel_packer_if #(.IN_WIDTH(24), .OUT_WIDTH(32), .DROP_CNT_W(16)) busB ();
  hdmi_pixel_packer_if #(.IN_WIDTH(56), .OUT_WIDTH(64), .DROP_CNT_W(16)) busC ();

  hdmi_pixel_packer #(.IN_WIDTH(24), .OUT_WIDTH(32), .MSB_FIRST(1'b1)) dutA (
    .i_hdmiClock(clk), .i_nReset(nReset), .bus(busA)
  );
  hdmi_pixel_packer #(.IN_WIDTH(24), .OUT_WIDTH(32), .MSB_FIRST(1'b0)) dutB (
    .i_hdmiClock(clk), .i_nReset(nReset), .bus(busB)
  );
  hdmi_pixel_packer #(.IN_WIDTH(56), .OUT_WIDTH(64), .MSB_FIRST(1'b1)) dutC (
    .i_hdmiClock(clk), .i_nReset(nReset), .bus(busC)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives A and B identically: data, dataEnable, hdmiEnable, vSync, fifoFull, clearStatus.
  task automatic drive(input logic [23:0] d, input logic de, input logic en, input logic vs,
                       input logic full, input logic clr);
    busA.hdmiData = d;  busA.dataEnable = de; busA.hdmiEnable = en; busA.vSync = vs;
    busA.fifoFull = full; busA.clearStatus = clr; busA.hSync = 1'b0;
    busB.hdmiData = d;  busB.dataEnable = de; busB.hdmiEnable = en; busB.vSync = vs;
    busB.fifoFull = full; busB.clearStatus = clr; busB.hSync = 1'b0;
  endtask

  task automatic chkWord(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, 64'(busA.dataValid), 64'd1);
    chk({tag, "_data"}, 64'(busA.fifoData), 64'(exp));
  endtask

  initial begin
    nReset = 1'b0;
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    busC.hdmiData = '0; busC.dataEnable = 1'b0; busC.hdmiEnable = 1'b0; busC.hSync = 1'b0;
    busC.vSync = 1'b0; busC.fifoFull = 1'b0; busC.clearStatus = 1'b0;
    cyc(); cyc();
    chk("rst_data", 64'(busA.fifoData), 64'd0);
    chk("rst_valid", 64'(busA.dataValid), 64'd0);
    chk("rst_ovf", 64'(busA.overflow), 64'd0);
    chk("rst_cnt", 64'(busA.dropCount), 64'd0);
    nReset = 1'b1;

    // Basic packing, plus LSB-first ordering on instance B
    drive(24'hAABBCC, 1, 1, 0, 0, 0); cyc(); chk("t1_p1_novalid", 64'(busA.dataValid), 64'd0);
    drive(24'h112233, 1, 1, 0, 0, 0); cyc(); chkWord("t1_w1", 32'hAABBCC11);
    chk("t3_lsb_valid", 64'(busB.dataValid), 64'd1);
    chk("t3_lsb_data", 64'(busB.fifoData), 64'h11CCBBAA);
    drive(24'h445566, 1, 1, 0, 0, 0); cyc(); chkWord("t1_w2", 32'h22334455);
    drive(24'h778899, 1, 1, 0, 0, 0); cyc(); chkWord("t1_w3", 32'h66778899);
    drive(24'h0, 0, 1, 0, 0, 0); cyc(); chk("t1_idle", 64'(busA.dataValid), 64'd0);

    // Vsync flush with zero padding, then realignment at byte 0
    drive(24'hAABBCC, 1, 1, 0, 0, 0); cyc();
    drive(24'h112233, 1, 1, 0, 0, 0); cyc(); chkWord("t2_w1", 32'hAABBCC11);
    drive(24'h0, 0, 1, 1, 0, 0); cyc(); chkWord("t2_flush", 32'h22330000);
    drive(24'h445566, 1, 1, 0, 0, 0); cyc(); chk("t2_p3_novalid", 64'(busA.dataValid), 64'd0);
    drive(24'h778899, 1, 1, 0, 0, 0); cyc(); chkWord("t2_w2", 32'h44556677);
    drive(24'h0, 0, 1, 1, 0, 0); cyc(); chkWord("t2_flush2", 32'h88990000);
    drive(24'h0, 0, 1, 0, 0, 0); cyc();

    // Ingest disabled: pixel and vsync edge both ignored, accumulator held
    drive(24'hAABBCC, 1, 1, 0, 0, 0); cyc();
    drive(24'h112233, 1, 0, 1, 0, 0); cyc(); chk("en_off_valid", 64'(busA.dataValid), 64'd0);
    drive(24'h112233, 1, 1, 0, 0, 0); cyc(); chkWord("en_resume", 32'hAABBCC11);
    drive(24'h0, 0, 1, 1, 0, 0); cyc(); chkWord("en_flush", 32'h22330000);
    drive(24'h0, 0, 1, 0, 0, 0); cyc();

    // FIFO full drop keeps alignment; clear, then clear coincident with drop
    drive(24'hAABBCC, 1, 1, 0, 0, 0); cyc();
    drive(24'h112233, 1, 1, 0, 1, 0); cyc();
    chk("t4_drop_valid", 64'(busA.dataValid), 64'd0);
    chk("t4_drop_ovf", 64'(busA.overflow), 64'd1);
    chk("t4_drop_cnt", 64'(busA.dropCount), 64'd1);
    drive(24'h445566, 1, 1, 0, 0, 0); cyc(); chkWord("t4_w2", 32'h22334455);
    drive(24'h778899, 1, 1, 0, 0, 0); cyc(); chkWord("t4_w3", 32'h66778899);
    chk("t4_ovf_sticky", 64'(busA.overflow), 64'd1);
    drive(24'h0, 0, 1, 0, 0, 1); cyc();
    chk("t4_clr_ovf", 64'(busA.overflow), 64'd0);
    chk("t4_clr_cnt", 64'(busA.dropCount), 64'd0);
    drive(24'hAABBCC, 1, 1, 0, 0, 0); cyc();
    drive(24'h112233, 1, 1, 0, 1, 1); cyc();
    chk("clrdrop_cnt", 64'(busA.dropCount), 64'd1);
    chk("clrdrop_ovf", 64'(busA.overflow), 64'd1);
    drive(24'h0, 0, 1, 0, 0, 1); cyc(); chk("clrdrop_clr", 64'(busA.dropCount), 64'd0);

    // Reset mid-word discards residual bytes and status
    drive(24'h445566, 1, 1, 0, 1, 0); cyc(); chk("t5_pre_cnt", 64'(busA.dropCount), 64'd1);
    nReset = 1'b0;
    drive(24'h0, 0, 0, 0, 0, 0); cyc();
    chk("t5_rst_data", 64'(busA.fifoData), 64'd0);
    chk("t5_rst_valid", 64'(busA.dataValid), 64'd0);
    chk("t5_rst_ovf", 64'(busA.overflow), 64'd0);
    chk("t5_rst_cnt", 64'(busA.dropCount), 64'd0);
    nReset = 1'b1;
    drive(24'hAABBCC, 1, 1, 0, 0, 0); cyc(); chk("t5_p1_novalid", 64'(busA.dataValid), 64'd0);
    drive(24'h112233, 1, 1, 0, 0, 0); cyc(); chkWord("t5_w1", 32'hAABBCC11);
    drive(24'h445566, 1, 1, 0, 0, 0); cyc(); chkWord("t5_w2", 32'h22334455);
    drive(24'h778899, 1, 1, 0, 0, 0); cyc(); chkWord("t5_w3", 32'h66778899);
    drive(24'h0, 0, 1, 1, 0, 0); cyc(); chk("empty_flush", 64'(busA.dataValid), 64'd0);
    drive(24'h0, 0, 1, 0, 0, 0); cyc();

    // Drop counter saturation: 8 pixels of 7 bytes into 8-byte words give 7 drops
    busC.hdmiData = 56'h01020304050607; busC.dataEnable = 1'b1; busC.hdmiEnable = 1'b1;
    busC.fifoFull = 1'b1;
    for (int n = 0; n < 8; n++) cyc();
    chk("t6_cnt7", 64'(busC.dropCount), 64'd7);
    for (int n = 0; n < 79992; n++) cyc();
    chk("t6_sat_cnt", 64'(busC.dropCount), 64'hFFFF);
    chk("t6_sat_ovf", 64'(busC.overflow), 64'd1);
    chk("t6_sat_valid", 64'(busC.dataValid), 64'd0);
    busC.dataEnable = 1'b0; busC.fifoFull = 1'b0; busC.clearStatus = 1'b1;
    cyc();
    busC.clearStatus = 1'b0;
    chk("t6_clr_cnt", 64'(busC.dropCount), 64'd0);
    chk("t6_clr_ovf", 64'(busC.overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
